hanning_frame_feeder: RTL and testbench

- Upstream stage of the Hanning window block: collects the incoming audio sample stream into a circular buffer and forms 128-sample frames with 50% overlap (hop 64).
- Sends each frame to the window stage one sample at a time. Each sample goes out with a single-cycle start strobe, a 7-bit index and signed data.
- The feeder then waits for the window stage's one-cycle ready pulse before sending the next sample.

---
 rtl/hanning_frame_feeder.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_hanning_frame_feeder.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hanning_frame_feeder.sv
// -----------------------------------------------------------------------------
// hanning_frame_feeder
//
// Upstream stage of the Hanning window block. Incoming audio samples are
// written into a circular buffer; every 128 samples (first frame) and then
// every HOP samples a frame of the most recent 128 samples is handed to the
// window stage one sample at a time. Each sample is presented with a one-cycle
// win_start strobe, its index within the frame and its data; the next sample
// is only sent after the window stage answers with a one-cycle win_ready.
//
// Optional build macro:
//   HANNING_FEEDER_TIMEOUT_EN  adds a WAIT watchdog and the timeout_err port.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   sample_valid  sample_in is valid this cycle
//   sample_in     signed audio sample
//   win_start     one-cycle strobe to the window stage
//   win_index     sample index within the frame (0..127)
//   win_data      sample data, stable from win_start until win_ready
//   win_ready     one-cycle completion pulse from the window stage
//   frame_first   high with win_start when win_index == 0
//   frame_last    high with win_start when win_index == 127
//   busy          a frame is in progress
//   overrun       sticky error flag (pending overflow or unread-slot overwrite)
//   clr_overrun   synchronous clear of overrun (and timeout_err)
//   timeout_err   sticky watchdog flag (only with HANNING_FEEDER_TIMEOUT_EN)
//
// FSM states:
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no frame active, waiting for a trigger or a pending frame
//   FETCH   | synchronous buffer read of buf[rd_ptr]
//   ISSUE   | win_start high, win_data/win_index presented
//   WAIT    | holding outputs until win_ready
// -----------------------------------------------------------------------------
module hanning_frame_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int HOP        = 64,
  parameter int ADDR_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  output logic                         win_start,
  output logic        [6:0]            win_index,
  output logic signed [DATA_WIDTH-1:0] win_data,
  input  logic                         win_ready,
  output logic                         frame_first,
  output logic                         frame_last,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         clr_overrun
`ifdef HANNING_FEEDER_TIMEOUT_EN
  ,
  output logic                         timeout_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [7:0]        FRAME_LEN = 8'd128;
  localparam logic [7:0]        FILL_LAST = 8'd127;
  localparam logic [7:0]        HOP_LAST  = 8'(HOP - 1);
  localparam logic [6:0]        IDX_LAST  = 7'd127;
  localparam logic [ADDR_W-1:0] BASE_BACK = ADDR_W'(127);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] pend_base;
  logic [ADDR_W-1:0] new_base;
  logic [ADDR_W-1:0] wr_gap;
  logic [7:0]        fill;
  logic [7:0]        hop_cnt;
  logic [6:0]        idx;
  logic [6:0]        remaining;
  logic [1:0]        state;
  logic [1:0]        state_n;
  logic              pending;

  logic first_done;
  logic trigger;
  logic frame_done;
  logic take_pending;
  logic start_trig;
  logic pend_store;
  logic pend_over;
  logic overwrite;
  logic wd_expired;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sample_valid) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  // fill saturates at 128; from then on hop_cnt paces the later frames.
  assign first_done = (fill == FRAME_LEN);
  assign trigger    = sample_valid &&
                      (first_done ? (hop_cnt == HOP_LAST) : (fill == FILL_LAST));

  // Base of the new frame: the write pointer after this write, minus 128.
  assign new_base = wr_ptr - BASE_BACK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      fill    <= '0;
      hop_cnt <= '0;
    end else if (sample_valid) begin
      wr_ptr <= wr_ptr + ONE_A;
      if (!first_done) begin
        fill <= fill + 8'd1;
      end else if (trigger) begin
        hop_cnt <= '0;
      end else begin
        hop_cnt <= hop_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame scheduling and error detection
  // ---------------------------------------------------------------------------
  assign frame_done   = (state == S_WAIT) && win_ready && (idx == IDX_LAST);
  assign take_pending = pending && ((state == S_IDLE) || frame_done);
  assign start_trig   = trigger && (state == S_IDLE) && !pending;

  // A trigger that does not start a frame directly must be parked. The pending
  // slot is free if it is empty or is being consumed in this very cycle.
  assign pend_store = trigger && !start_trig;
  assign pend_over  = pend_store && pending && !take_pending;

  // Slots rd_ptr+1 .. base+127 of the active frame are still unread. The slot
  // at rd_ptr is either already read or read this cycle with old data.
  assign wr_gap    = wr_ptr - rd_ptr - ONE_A;
  assign remaining = IDX_LAST - idx;
  assign overwrite = sample_valid && (state != S_IDLE) &&
                     (wr_gap < ADDR_W'(remaining));

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Optional WAIT watchdog: down-counter loaded in ISSUE, expiry at zero gives
  // a resend period of 42 cycles.
  // ---------------------------------------------------------------------------
`ifdef HANNING_FEEDER_TIMEOUT_EN
  localparam logic [5:0] WD_LOAD = 6'd40;

  logic [5:0] wd_cnt;

  assign wd_expired = (state == S_WAIT) && !win_ready && (wd_cnt == 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        wd_cnt <= WD_LOAD;
      end else if ((state == S_WAIT) && (wd_cnt != 6'd0)) begin
        wd_cnt <= wd_cnt - 6'd1;
      end
      timeout_err <= wd_expired || (timeout_err && !clr_overrun);
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (pending || trigger) begin
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (win_ready) begin
          if (idx == IDX_LAST) begin
            state_n = pending ? S_FETCH : S_IDLE;
          end else begin
            state_n = S_FETCH;
          end
        end else if (wd_expired) begin
          state_n = S_ISSUE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rd_ptr      <= '0;
      idx         <= '0;
      win_data    <= '0;
      win_index   <= '0;
      win_start   <= 1'b0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      state <= state_n;

      case (state)
        S_IDLE: begin
          if (pending) begin
            rd_ptr <= pend_base;
            idx    <= '0;
          end else if (start_trig) begin
            rd_ptr <= new_base;
            idx    <= '0;
          end
        end
        S_FETCH: begin
          // Registered read doubles as the win_data holding register; it only
          // changes on the next FETCH, so the data stays stable through WAIT.
          win_data  <= mem[rd_ptr];
          win_index <= idx;
        end
        S_WAIT: begin
          if (win_ready) begin
            if (idx == IDX_LAST) begin
              if (pending) begin
                rd_ptr <= pend_base;
                idx    <= '0;
              end
            end else begin
              idx    <= idx + 7'd1;
              rd_ptr <= rd_ptr + ONE_A;
            end
          end
        end
        default: ;
      endcase

      // idx is stable in both states that lead to ISSUE (FETCH, watchdog).
      win_start   <= (state_n == S_ISSUE);
      frame_first <= (state_n == S_ISSUE) && (idx == 7'd0);
      frame_last  <= (state_n == S_ISSUE) && (idx == IDX_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      pend_base <= '0;
      overrun   <= 1'b0;
    end else begin
      if (pend_store && (!pending || take_pending)) begin
        pending   <= 1'b1;
        pend_base <= new_base;
      end else if (take_pending) begin
        pending <= 1'b0;
      end
      // A new error in the clearing cycle wins over clr_overrun.
      overrun <= pend_over || overwrite || (overrun && !clr_overrun);
    end
  end

endmodule

// File: tb/tb_hanning_frame_feeder.sv
// -----------------------------------------------------------------------------
// tb_hanning_frame_feeder
//
// Directed bench for hanning_frame_feeder. A window-stage stub answers each
// win_start with a win_ready 17 cycles later; a monitor records every start
// (index, data, first, last). Each test task drives its scenario and compares
// against hand-derived values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hanning_frame_feeder;

  logic               clk;
  logic               rst_n;
  logic               sample_valid;
  logic signed [31:0] sample_in;
  logic               win_start;
  logic [6:0]         win_index;
  logic signed [31:0] win_data;
  logic               stub_ready;
  logic               poke_ready;
  logic               frame_first;
  logic               frame_last;
  logic               busy;
  logic               overrun;
  logic               clr_overrun;
`ifdef HANNING_FEEDER_TIMEOUT_EN
  logic               timeout_err;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  logic stub_en     = 1'b1;

  logic [6:0]  q_idx[$];
  logic [31:0] q_data[$];
  logic        q_first[$];
  logic        q_last[$];
  logic [31:0] exp_s [0:383];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  hanning_frame_feeder #(
    .DATA_WIDTH(32),
    .HOP(64),
    .ADDR_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_valid(sample_valid),
    .sample_in(sample_in),
    .win_start(win_start),
    .win_index(win_index),
    .win_data(win_data),
    .win_ready(stub_ready | poke_ready),
    .frame_first(frame_first),
    .frame_last(frame_last),
    .busy(busy),
    .overrun(overrun),
    .clr_overrun(clr_overrun)
`ifdef HANNING_FEEDER_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (win_start === 1'b1) begin
        q_idx.push_back(win_index);
        q_data.push_back(win_data);
        q_first.push_back(frame_first);
        q_last.push_back(frame_last);
      end
    end
  end

  initial begin : window_stub
    stub_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stub_en === 1'b1 && win_start === 1'b1) begin
        repeat (17) @(negedge clk);
        stub_ready = 1'b1;
        @(negedge clk);
        stub_ready = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    clr_overrun  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic feed_seq(input int n, input logic [31:0] base_val);
    for (int k = 0; k < n; k++) begin
      sample_valid = 1'b1;
      sample_in    = base_val + 32'(k);
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  task automatic feed_exp(input int from, input int n);
    for (int k = 0; k < n; k++) begin
      sample_valid = 1'b1;
      sample_in    = exp_s[from + k];
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    int t = 0;
    while (q_idx.size() < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (q_idx.size() < target) begin
      miscompares++;
      $display("FAIL %s: starts seen %0d, required %0d", name, q_idx.size(), target);
    end
  endtask

  task automatic wait_index(input logic [6:0] want, input int budget, input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(win_start === 1'b1 && win_index === want) && t < budget);
    vectors++;
    if (!(win_start === 1'b1 && win_index === want)) begin
      miscompares++;
      $display("FAIL %s: no start with index %0d within %0d cycles", name, want, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    clr_overrun  = 1'b0;
    poke_ready   = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({win_start, frame_first, frame_last, busy, overrun} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 00000",
               {win_start, frame_first, frame_last, busy, overrun});
    end
    vectors++;
    if (win_index !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_index: got %0d, required 0", win_index);
    end
    vectors++;
    if (win_data !== 32'sd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, required 0", win_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    // win_ready while IDLE must be ignored
    poke_ready = 1'b1;
    @(negedge clk);
    poke_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || win_start !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ready_ignored: busy=%b win_start=%b, required 0 0", busy, win_start);
    end
  endtask

  task automatic test_first_frame();
    int mark;
    mark = q_idx.size();
    feed_seq(128, 32'd0);
    // one cycle after the trigger cycle: FETCH
    vectors++;
    if (win_start !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_fetch: win_start=%b busy=%b, required 0 1", win_start, busy);
    end
    @(negedge clk);
    vectors++;
    if (win_start !== 1'b1 || win_index !== 7'd0 || frame_first !== 1'b1 || win_data !== 32'sd0) begin
      miscompares++;
      $display("FAIL latency_first_start: start=%b idx=%0d first=%b data=%h, required 1 0 1 0",
               win_start, win_index, frame_first, win_data);
    end
    wait_count(mark + 128, 128 * 19 + 100, "frame1_count");
    wait_idle(60, "frame1_idle");
    vectors++;
    if (q_idx.size() != mark + 128) begin
      miscompares++;
      $display("FAIL frame1_exact_count: got %0d, required %0d", q_idx.size() - mark, 128);
    end
    for (int i = 0; i < 128 && mark + i < q_idx.size(); i++) begin
      vectors++;
      if (q_idx[mark + i] !== 7'(i)) begin
        miscompares++;
        $display("FAIL frame1_index[%0d]: got %0d, required %0d", i, q_idx[mark + i], i);
      end
      vectors++;
      if (q_data[mark + i] !== 32'(i)) begin
        miscompares++;
        $display("FAIL frame1_data[%0d]: got %h, required %h", i, q_data[mark + i], 32'(i));
      end
      vectors++;
      if (q_first[mark + i] !== (i == 0) || q_last[mark + i] !== (i == 127)) begin
        miscompares++;
        $display("FAIL frame1_flags[%0d]: first=%b last=%b, required %b %b",
                 i, q_first[mark + i], q_last[mark + i], (i == 0), (i == 127));
      end
    end
  endtask

  task automatic test_overlap();
    int mark;
    mark = q_idx.size();
    feed_seq(64, 32'd128);
    wait_index(7'd127, 128 * 19 + 200, "frame2_last");
    repeat (17) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_before_final_ready: got %b, required 1", busy);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_final_ready: got %b, required 0", busy);
    end
    vectors++;
    if (q_idx.size() != mark + 128) begin
      miscompares++;
      $display("FAIL frame2_count: got %0d, required 128", q_idx.size() - mark);
    end
    for (int i = 0; i < 128 && mark + i < q_idx.size(); i++) begin
      vectors++;
      if (q_idx[mark + i] !== 7'(i) || q_data[mark + i] !== 32'(64 + i)) begin
        miscompares++;
        $display("FAIL frame2_sample[%0d]: idx=%0d data=%0d, required %0d %0d",
                 i, q_idx[mark + i], q_data[mark + i], i, 64 + i);
      end
    end
  endtask

  task automatic test_pending_overrun();
    do_reset();
    feed_seq(192, 32'd0);
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_after_trig2: got %b, required 0", overrun);
    end
    vectors++;
    if (dut.pending !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_after_trig2: got %b, required 1", dut.pending);
    end
    feed_seq(64, 32'd192);
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_after_trig3: got %b, required 1", overrun);
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_cleared: got %b, required 0", overrun);
    end
    // clear held while writes land on unread slots: the new error wins
    clr_overrun = 1'b1;
    feed_seq(64, 32'd256);
    clr_overrun = 1'b0;
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set_beats_clear: got %b, required 1", overrun);
    end
    @(negedge clk);
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_cleared_again: got %b, required 0", overrun);
    end
  endtask

  task automatic test_full_scale_wrap();
    int mark;
    for (int j = 0; j < 384; j++) begin
      case (j % 3)
        0:       exp_s[j] = 32'h8000_0000;
        1:       exp_s[j] = 32'h7FFF_FFFF;
        default: exp_s[j] = (32'(j) * 32'h0101_0101) ^ 32'hA5A5_0000;
      endcase
    end
    do_reset();
    mark = q_idx.size();
    feed_exp(0, 128);
    wait_count(mark + 128, 128 * 19 + 200, "wrap_frame0_count");
    wait_idle(60, "wrap_frame0_idle");
    for (int f = 1; f < 5; f++) begin
      feed_exp(128 + (f - 1) * 64, 64);
      wait_count(mark + 128 * (f + 1), 128 * 19 + 200, "wrap_frame_count");
      wait_idle(60, "wrap_frame_idle");
    end
    vectors++;
    if (q_idx.size() != mark + 640) begin
      miscompares++;
      $display("FAIL wrap_total_starts: got %0d, required 640", q_idx.size() - mark);
    end
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 128 && mark + f * 128 + i < q_idx.size(); i++) begin
        vectors++;
        if (q_idx[mark + f * 128 + i] !== 7'(i) ||
            q_data[mark + f * 128 + i] !== exp_s[f * 64 + i]) begin
          miscompares++;
          $display("FAIL wrap_f%0d[%0d]: idx=%0d data=%h, required %0d %h",
                   f, i, q_idx[mark + f * 128 + i], q_data[mark + f * 128 + i],
                   i, exp_s[f * 64 + i]);
        end
      end
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_no_overrun: got %b, required 0", overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    int mark;
    do_reset();
    feed_seq(128, 32'd500);
    wait_index(7'd50, 51 * 19 + 100, "midframe_index50");
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({win_start, frame_first, frame_last, busy, overrun} !== 5'b0 ||
        win_index !== 7'd0 || win_data !== 32'sd0) begin
      miscompares++;
      $display("FAIL midframe_reset_outputs: flags=%b idx=%0d data=%h, required 0",
               {win_start, frame_first, frame_last, busy, overrun}, win_index, win_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mark = q_idx.size();
    repeat (60) @(negedge clk);
    vectors++;
    if (q_idx.size() != mark || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_no_restart: starts=%0d busy=%b, required 0 0",
               q_idx.size() - mark, busy);
    end
    feed_seq(127, 32'd2000);
    repeat (5) @(negedge clk);
    vectors++;
    if (q_idx.size() != mark || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_127_fresh: starts=%0d busy=%b, required 0 0",
               q_idx.size() - mark, busy);
    end
    feed_seq(1, 32'd2127);
    vectors++;
    if (win_start !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_early_start: got %b, required 0", win_start);
    end
    @(negedge clk);
    vectors++;
    if (win_start !== 1'b1 || win_index !== 7'd0 || win_data !== 32'sd2000) begin
      miscompares++;
      $display("FAIL midframe_new_frame: start=%b idx=%0d data=%0d, required 1 0 2000",
               win_start, win_index, win_data);
    end
  endtask

`ifdef HANNING_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    stub_en = 1'b0;
    do_reset();
    feed_seq(128, 32'd3000);
    wait_index(7'd0, 20, "timeout_first_start");
    vectors++;
    if (timeout_err !== 1'b0 || win_data !== 32'sd3000) begin
      miscompares++;
      $display("FAIL timeout_initial: err=%b data=%0d, required 0 3000", timeout_err, win_data);
    end
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (win_start !== 1'b1 && n < 100);
      vectors++;
      if (n != 42 || win_index !== 7'd0 || win_data !== 32'sd3000 || timeout_err !== 1'b1) begin
        miscompares++;
        $display("FAIL timeout_resend%0d: gap=%0d idx=%0d data=%0d err=%b, required 42 0 3000 1",
                 r, n, win_index, win_data, timeout_err);
      end
    end
    stub_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_overlap();
    test_pending_overrun();
    test_full_scale_wrap();
    test_reset_mid_frame();
`ifdef HANNING_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
